// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: shapes core byte/half/word loads and stores into 32-bit word accesses.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses instead of issuing them.
module lsu_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        misalign_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e            state_r, state_d;
  logic              accept_s, trap_s, hit_s, timeout_s, misalign_s;
  logic              we_r;
  logic [2:0]        size_r;
  logic [31:0]       addr_r;
  logic [3:0]        be_r;
  logic [31:0]       wd_r;
  logic [CNT_W-1:0]  cnt_r;

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      3'd0, 3'd4: store_be = 4'b0001 << addr;
      3'd1, 3'd5: store_be = addr[1] ? 4'b1100 : 4'b0011;
      default:    store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0, 3'd4: store_wd = {4{wd[7:0]}};
      3'd1, 3'd5: store_wd = {2{wd[15:0]}};
      default:    store_wd = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_shape(input logic [2:0] size, input logic [1:0] addr,
                                             input logic [31:0] rd);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = rd[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? rd[31:16] : rd[15:0];
    case (size)
      3'd0:    load_shape = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_shape = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_shape = {24'd0, lane_b};
      3'd5:    load_shape = {16'd0, lane_h};
      default: load_shape = rd;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      3'd0, 3'd4: is_misaligned = 1'b0;
      3'd1, 3'd5: is_misaligned = addr[0];
      default:    is_misaligned = (addr != 2'b00);
    endcase
  endfunction

  assign misalign_s = is_misaligned(core_size_i, core_addr_i[1:0]);

  // Trap flag is visible for exactly the DONE cycle entered from IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= trap_s;
    end
  end
`else
  assign misalign_s = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Next-state logic and transition qualifiers shared with the datapath.
  always_comb begin
    state_d   = state_r;
    accept_s  = 1'b0;
    trap_s    = 1'b0;
    hit_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (core_req_i && misalign_s) begin
          trap_s  = 1'b1;
          state_d = ST_DONE;
        end else if (core_req_i) begin
          accept_s = 1'b1;
          state_d  = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ready_i) begin
          hit_s   = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port and stall decode; the port is idle outside ACCESS.
  always_comb begin
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    case (state_r)
      ST_IDLE: core_stall_o = core_req_i;
      ST_ACCESS: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = we_r;
        mem_be_o     = be_r;
        mem_addr_o   = {addr_r[31:2], 2'b00};
        mem_wd_o     = wd_r;
      end
      ST_DONE: core_stall_o = 1'b0;
      default: core_stall_o = 1'b0;
    endcase
  end

  // Request latch, timeout counter and registered core-side results.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_r       <= 1'b0;
      size_r     <= 3'd0;
      addr_r     <= 32'd0;
      be_r       <= 4'b0000;
      wd_r       <= 32'd0;
      cnt_r      <= '0;
      core_rd_o  <= 32'd0;
      core_err_o <= 1'b0;
    end else begin
      core_err_o <= timeout_s | trap_s;
      if (accept_s) begin
        we_r   <= core_we_i;
        size_r <= core_size_i;
        addr_r <= core_addr_i;
        be_r   <= core_we_i ? store_be(core_size_i, core_addr_i[1:0]) : 4'b1111;
        wd_r   <= store_wd(core_size_i, core_wd_i);
        cnt_r  <= '0;
      end else if (state_r == ST_ACCESS && !mem_ready_i) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (hit_s) begin
        if (!we_r) begin
          core_rd_o <= load_shape(size_r, addr_r[1:0], mem_rd_i);
        end
      end else if (timeout_s) begin
        core_rd_o <= 32'hdead_beef;
      end
    end
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the core side of the data-memory request interface (mem_req / write_enable / addr / write_data / read_data).
- Accepts one core load/store and shapes byte/half/word data into 32-bit word accesses with byte enables.
- Stalls the core until the responder signals ready, then returns the sign- or zero-extended load result.
- Sits between the execute stage and the data memory.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for mem_ready_i before abort (>=2)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous, active-low reset
core_req_i  input  1  core requests load/store; held high until core_stall_o is low
core_we_i  input  1  1 = store, 0 = load
core_size_i  input  3  RISC-V funct3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU
core_addr_i  input  32  byte address
core_wd_i  input  32  store data, in the low bits
core_rd_o  output  32  load result, extended
core_stall_o  output  1  core must hold the pipeline
core_err_o  output  1  1-cycle pulse: timeout or misalign abort
mem_req_o  output  1  memory request
mem_we_o  output  1  memory write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  32  word address: {addr[31:2], 2'b00}
mem_wd_o  output  32  lane-replicated write data
mem_rd_i  input  32  memory read word
mem_ready_i  input  1  response valid / write accepted this cycle
misalign_o  output  1  1-cycle pulse: misaligned access trapped (MISALIGN_TRAP_EN only)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset state: IDLE. All outputs 0, including core_rd_o, and the timeout counter is 0.
- Reset mid-operation: on the next edge, state returns to IDLE and mem_req_o drops. No partial result or error is reported.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - core_stall_o = core_req_i (combinational).
  - On core_req_i = 1, latch addr, we, size, shaped write data and byte enables. Clear the counter and go to ACCESS.
- ACCESS:
  - mem_req_o = 1 and core_stall_o = 1.
  - mem_we_o, mem_be_o, mem_addr_o and mem_wd_o come from the latched values and are stable for the whole state.
  - On mem_ready_i = 1: register the shaped load result into core_rd_o (stores leave core_rd_o unchanged). Go to DONE.
  - Otherwise increment the counter. When counter = TIMEOUT_CYCLES-1 without ready: core_rd_o = 32'hdead_beef, core_err_o pulses in DONE, go to DONE.
- DONE:
  - mem_req_o = 0 and core_stall_o = 0.
  - core_rd_o is valid for this cycle and then held.
  - core_req_i is ignored this cycle. Always go to IDLE.
- Best-case load timing with ready in the first ACCESS cycle:
  - Accept cycle: stall.
  - ACCESS cycle: stall, ready.
  - DONE cycle: no stall.
  - The pipeline therefore sees 2 stall cycles.
- Store shaping:
  - B: byte replicated to all 4 lanes; be = 4'b0001 << addr[1:0].
  - H: half replicated to both halves; be = addr[1] ? 4'b1100 : 4'b0011.
  - W: be = 4'b1111.
- Load shaping:
  - Select the byte lane addr[1:0], or the half lane addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Unlisted sizes (3, 6, 7) are treated as W.
- Loads drive mem_be_o = 4'b1111 and mem_we_o = 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access is H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - On a misaligned access, IDLE goes straight to DONE with no mem_req_o.
  - In DONE: misalign_o = 1 and core_err_o = 1; core_rd_o is unchanged.
- Undefined:
  - misalign_o is tied 0.
  - Misaligned accesses proceed: H ignores addr[0] and W ignores addr[1:0].

Test Plan:
- SW 0x11223344 to 0x100, ready on first ACCESS cycle -> mem_be_o = 4'b1111, mem_wd_o = 0x11223344, mem_addr_o = 0x100, stall 2 cycles.
- SB 0xA5 to 0x103 -> mem_be_o = 4'b1000, mem_wd_o = 0xA5A5A5A5; then LB from 0x103 with mem_rd_i = 0xA5000000 -> core_rd_o = 0xFFFFFFA5; LBU -> 0x000000A5.
- LH from 0x102 with mem_rd_i = 0x80017FFF -> core_rd_o = 0xFFFF8001; LHU -> 0x00008001.
- mem_ready_i held 0, TIMEOUT_CYCLES = 16 -> 16 ACCESS cycles, then DONE with core_rd_o = 0xDEADBEEF, core_err_o pulse, mem_req_o = 0.
- rst_ni = 0 during ACCESS -> next cycle IDLE, mem_req_o = 0, core_stall_o = 0 with core_req_i low, core_rd_o = 0.
- With MISALIGN_TRAP_EN, LW from 0x102 -> no mem_req_o, misalign_o = 1 for one cycle, 1 stall cycle. Without the macro -> word read at 0x100.
